// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial signed adder/subtractor.
// Processes DIGIT bits per cycle, LSB slice first, and publishes r/co/of
// together with a one-cycle done pulse after WIDTH/DIGIT RUN cycles.
module addsub_serial #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
   input  logic             ci,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] r,
   output logic             co,
   output logic             of
);

   localparam int N   = WIDTH / DIGIT;
   localparam int CW  = (N > 1) ? $clog2(N) : 1;
   localparam int MSB = WIDTH - 1;

   generate
      if (WIDTH < 2 || WIDTH > 64 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
         $error("addsub_serial: illegal WIDTH/DIGIT combination");
      end
   endgenerate

   typedef enum logic {IDLE, RUN} state_t;
   state_t state, state_n;

   logic [WIDTH-1:0] xq, yq, acc, acc_n;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic [DIGIT-1:0] xs, ys;
   logic [DIGIT:0]   sum;
   logic             last;

   assign busy = (state == RUN);
   assign last = (cnt == CW'(N - 1));

   // Select the current operand slices, add them with the carry and
   // place the sum slice into the result accumulator.
   always_comb begin
      xs    = '0;
      ys    = '0;
      acc_n = acc;
      for (int i = 0; i < N; i++) begin
         if (cnt == CW'(i)) begin
            xs = xq[i*DIGIT +: DIGIT];
            ys = yq[i*DIGIT +: DIGIT];
         end
      end
      sum = {1'b0, xs} + {1'b0, ys} + {{DIGIT{1'b0}}, carry};
      for (int i = 0; i < N; i++) begin
         if (cnt == CW'(i)) acc_n[i*DIGIT +: DIGIT] = sum[DIGIT-1:0];
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Next-state: start launches a run, the final slice returns to IDLE.
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = RUN;
         RUN:     if (last)  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Operand latching, per-slice accumulation and result publication.
   // Inverting y and the carry-in on subtract turns x-y-ci into x+~y+~ci.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xq    <= '0;
         yq    <= '0;
         acc   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         r     <= '0;
         co    <= 1'b0;
         of    <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE && start) begin
            xq    <= x;
            yq    <= y ^ {WIDTH{op}};
            carry <= op ^ ci;
            cnt   <= '0;
            acc   <= '0;
         end else if (state == RUN) begin
            acc   <= acc_n;
            carry <= sum[DIGIT];
            cnt   <= cnt + CW'(1);
            if (last) begin
               cnt  <= '0;
               r    <= acc_n;
               co   <= sum[DIGIT];
               // Overflow uses the effective (possibly inverted) y operand.
               of   <= (xq[MSB] ~^ yq[MSB]) & (acc_n[MSB] ^ xq[MSB]);
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: DIGIT=2 and DIGIT=8 instances at WIDTH=8,
// directed corner cases plus random operations against an arithmetic model.
module tb_addsub_serial;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_s [2];
   logic       op_s    [2];
   logic       ci_s    [2];
   logic [7:0] x_s     [2];
   logic [7:0] y_s     [2];
   logic       busy_s  [2];
   logic       done_s  [2];
   logic [7:0] r_s     [2];
   logic       co_s    [2];
   logic       of_s    [2];

   int pass_cnt  = 0;
   int check_cnt = 0;

   always #5 clk = ~clk;

   addsub_serial #(.WIDTH(8), .DIGIT(2)) dut0 (
      .clk(clk), .rst(rst), .start(start_s[0]), .op(op_s[0]), .ci(ci_s[0]),
      .x(x_s[0]), .y(y_s[0]), .busy(busy_s[0]), .done(done_s[0]),
      .r(r_s[0]), .co(co_s[0]), .of(of_s[0])
   );

   addsub_serial #(.WIDTH(8), .DIGIT(8)) dut1 (
      .clk(clk), .rst(rst), .start(start_s[1]), .op(op_s[1]), .ci(ci_s[1]),
      .x(x_s[1]), .y(y_s[1]), .busy(busy_s[1]), .done(done_s[1]),
      .r(r_s[1]), .co(co_s[1]), .of(of_s[1])
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      check_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Reference: plain integer arithmetic on the unsigned and signed views.
   function automatic void model(input logic o, input logic c, input logic [7:0] a,
                                 input logic [7:0] b, output logic [7:0] rr,
                                 output logic cc, output logic oo);
      int u, s, sa, sb, ic;
      sa = $signed(a);
      sb = $signed(b);
      ic = c;
      if (!o) begin
         u = int'(a) + int'(b) + ic;
         s = sa + sb + ic;
      end else begin
         u = int'(a) + (255 - int'(b)) + (1 - ic);
         s = sa - sb - ic;
      end
      rr = u[7:0];
      cc = u[8];
      oo = (s > 127) || (s < -128);
   endfunction

   // Launch one operation on instance d (called #1 after an edge) and
   // follow it to completion. poke re-pulses start in RUN cycle 2.
   task automatic go(input int d, input logic o, input logic c,
                     input logic [7:0] a, input logic [7:0] b, input bit poke);
      logic [7:0] er, rprev;
      logic       eco, eof;
      int         n, k;
      model(o, c, a, b, er, eco, eof);
      n = (d == 0) ? 4 : 1;
      op_s[d] = o; ci_s[d] = c; x_s[d] = a; y_s[d] = b; start_s[d] = 1'b1;
      chk("busy_before_start", busy_s[d], 0);
      rprev = r_s[d];
      @(posedge clk); #1;
      start_s[d] = 1'b0;
      op_s[d] = 1'($urandom); ci_s[d] = 1'($urandom);
      x_s[d] = 8'($urandom); y_s[d] = 8'($urandom);
      k = 0;
      while (!done_s[d] && k < 12) begin
         chk("busy_run", busy_s[d], 1);
         chk("r_hold_run", r_s[d], rprev);
         if (poke && k == 1) begin
            start_s[d] = 1'b1;
            op_s[d] = ~o; x_s[d] = ~a; y_s[d] = a ^ b;
         end else begin
            start_s[d] = 1'b0;
         end
         @(posedge clk); #1;
         k++;
      end
      start_s[d] = 1'b0;
      chk("latency", 64'(k), 64'(n));
      chk("busy_at_done", busy_s[d], 0);
      chk("r", r_s[d], er);
      chk("co", co_s[d], eco);
      chk("of", of_s[d], eof);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit saw_done;
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         start_s[d] = 1'b0; op_s[d] = 1'b0; ci_s[d] = 1'b0; x_s[d] = '0; y_s[d] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("rst_busy", busy_s[d], 0);
         chk("rst_done", done_s[d], 0);
         chk("rst_r", r_s[d], 0);
         chk("rst_co", co_s[d], 0);
         chk("rst_of", of_s[d], 0);
      end
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed cases
      go(0, 1'b0, 1'b0, 8'h05, 8'h03, 1'b0);
      @(posedge clk); #1;
      chk("done_one_cycle", done_s[0], 0);
      go(0, 1'b0, 1'b0, 8'h7F, 8'h01, 1'b0);
      go(0, 1'b1, 1'b0, 8'h80, 8'h01, 1'b0);
      go(0, 1'b1, 1'b0, 8'h00, 8'h01, 1'b0);
      go(0, 1'b0, 1'b1, 8'h11, 8'h22, 1'b1);   // start re-pulsed mid-run
      @(posedge clk); #1;
      chk("no_restart_after_poke", busy_s[0], 0);

      // Reset during RUN cycle 2
      op_s[0] = 1'b0; ci_s[0] = 1'b0; x_s[0] = 8'h44; y_s[0] = 8'h11; start_s[0] = 1'b1;
      @(posedge clk); #1;
      start_s[0] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("abort_busy", busy_s[0], 0);
      chk("abort_r", r_s[0], 0);
      chk("abort_done", done_s[0], 0);
      @(posedge clk); #1;
      rst = 1'b0;
      saw_done = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (done_s[0]) saw_done = 1'b1;
      end
      chk("abort_no_done", saw_done, 0);
      go(0, 1'b0, 1'b0, 8'h10, 8'h20, 1'b0);

      // Back-to-back random operations: each start lands in the done cycle
      for (int i = 0; i < 20; i++)
         go(0, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'b0);

      // Single-cycle instance
      go(1, 1'b0, 1'b0, 8'hFF, 8'h01, 1'b0);
      go(1, 1'b1, 1'b1, 8'h80, 8'h7F, 1'b0);
      for (int i = 0; i < 10; i++)
         go(1, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      @(posedge clk); #1;
      chk("dut1_done_one_cycle", done_s[1], 0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule

// File: doc/addsub_serial.md
ADDSUB_SERIAL -- requirements
Module: addsub_serial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand and result width in bits; legal values are 2 to 64.
REQ-002 The block SHALL have parameter DIGIT, default 2: bits processed per cycle; 1 <= DIGIT <= WIDTH, and WIDTH % DIGIT == 0 is enforced at elaboration.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request a new operation; it is sampled on a rising clk edge while busy=0.
REQ-006 The block SHALL have port op, input, 1 bit: operation select, where 0 = add (x+y+ci) and 1 = subtract (x+~y+~ci, i.e. x-y-ci).
REQ-007 The block SHALL have port ci, input, 1 bit: carry-in for add, or borrow-in for subtract.
REQ-008 The block SHALL have port x, input, WIDTH bits: signed two's-complement operand.
REQ-009 The block SHALL have port y, input, WIDTH bits: signed two's-complement operand.
REQ-010 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: a one-cycle pulse marking that r, co and of are valid.
REQ-012 The block SHALL have port r, output, WIDTH bits: signed result.
REQ-013 The block SHALL have port co, output, 1 bit: carry out of the MSB; in subtract mode, 1 = no borrow.
REQ-014 The block SHALL have port of, output, 1 bit: signed overflow flag.

Function
REQ-015 The block SHALL have the states IDLE and RUN, and SHALL leave reset in IDLE.
- IDLE -> RUN: start=1.
- RUN -> IDLE: after the final digit.
REQ-016 On an accepted start the block SHALL latch the following:
- x;
- yeff = y XOR {WIDTH{op}};
- initial carry = op XOR ci;
- digit counter = 0.
REQ-017 In each RUN cycle the block SHALL add one DIGIT-bit slice, LSB slice first, together with the carry register; it SHALL write the sum slice into the result shift register and update the carry register.
REQ-018 A RUN operation SHALL take exactly N = WIDTH/DIGIT cycles: busy=1 for the N cycles following the accepting edge.
REQ-019 On the edge that completes the last slice, the block SHALL do the following:
- update r, co and of together;
- deassert busy;
- assert done for exactly one cycle.
REQ-020 co SHALL equal the carry out of bit WIDTH-1.
REQ-021 of SHALL equal (x[MSB] XNOR yeff[MSB]) AND (r[MSB] XOR x[MSB]), computed on yeff (not raw y) so that subtract overflow is correct.
REQ-022 r, co and of SHALL hold their values from the last completed operation until the next completion, and SHALL not change during RUN.
REQ-023 The block SHALL ignore start while busy=1, with no effect on the operation in progress or on the latched operands.
REQ-024 The block SHALL accept a start in the same cycle that done=1, giving back-to-back operations with no idle gap.
REQ-025 When DIGIT=WIDTH the block SHALL use N=1: done is asserted one cycle after the accepting edge.
REQ-026 Changes on x, y, op and ci after the accepting edge SHALL not affect the result.
REQ-027 Arithmetic SHALL wrap modulo 2^WIDTH, with no saturation.

Reset
REQ-028 While rst=1 the block SHALL immediately force the following, independent of clk:
- state = IDLE;
- busy = 0;
- done = 0;
- r = 0;
- co = 0;
- of = 0;
- all internal registers = 0.
REQ-029 A reset during RUN SHALL abort the operation with no done pulse; the first start after reset is released SHALL be accepted normally.

Verification (WIDTH=8, DIGIT=2 unless stated)
REQ-030 The bench SHALL cover add with x=0x05, y=0x03, ci=0 -> r=0x08, co=0, of=0; busy high for 4 cycles; done on the 4th edge after start.
REQ-031 The bench SHALL cover add with x=0x7F, y=0x01, ci=0 -> r=0x80, co=0, of=1.
REQ-032 The bench SHALL cover the following subtract cases:
- x=0x80, y=0x01, ci=0 -> r=0x7F, co=1, of=1;
- x=0x00, y=0x01, ci=0 -> r=0xFF, co=0, of=0.
REQ-033 The bench SHALL cover start pulsed again in RUN cycle 2 with different operands, which SHALL be ignored so that the first result appears.
REQ-034 The bench SHALL cover rst asserted in RUN cycle 2, which SHALL give busy=0, r=0 and no done; a subsequent x=0x10, y=0x20 add SHALL then give r=0x30.
REQ-035 The bench SHALL cover a start issued in the done cycle, which SHALL be accepted and complete 4 cycles later; with DIGIT=8, x=0xFF, y=0x01 add SHALL give r=0x00, co=1, of=0, with done 1 cycle after start.
